// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: state encoding, opcode/op fields and ALU/shift encodings for the datapath controller.
package datapath_ctrl_pkg;
   typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM} state_t;
   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_CMP = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_MVN = 2'b11;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_NOT = 2'b11;
   localparam logic [1:0] SH_NONE = 2'b00;
endpackage

// File: rtl/datapath_ctrl_instr_decode.sv
// instr_decode: splits the IR into register/shift fields, sign-extends imm8 and classifies the instruction.
module instr_decode
   import datapath_ctrl_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [DW-1:0] ir,
   output logic [2:0]    rn,
   output logic [2:0]    rd,
   output logic [2:0]    rm,
   output logic [1:0]    sh,
   output logic [1:0]    op,
   output logic [DW-1:0] datapath_in,
   output logic          legal,
   output logic          mov_imm,
   output logic          mov_reg,
   output logic          mvn,
   output logic          cmp,
   output logic          use_a
);
   logic [2:0] opc;
   logic       alu;
   assign opc = ir[15:13];
   assign op = ir[12:11];
   assign rn = ir[10:8];
   assign rd = ir[7:5];
   assign sh = ir[4:3];
   assign rm = ir[2:0];
   assign datapath_in = {{(DW-8){ir[7]}}, ir[7:0]};
   assign alu = opc == OPC_ALU;
   assign mov_imm = opc == OPC_MOV && op == OP_MOV_IMM;
   assign mov_reg = opc == OPC_MOV && op == OP_MOV_REG;
   assign mvn = alu && op == OP_MVN;
   assign cmp = alu && op == OP_CMP;
   // MVN and MOV reg only need the B operand
   assign use_a = alu && !mvn;
   assign legal = mov_imm || mov_reg || alu;
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle FSM that latches an instruction on the s handshake and sequences datapath strobes.
module datapath_ctrl
   import datapath_ctrl_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s,
   input  logic [DW-1:0] in,
   output logic          w,
   output logic          err,
   output logic [2:0]    readnum,
   output logic [2:0]    writenum,
   output logic          write,
   output logic          vsel,
   output logic          loada,
   output logic          loadb,
   output logic          asel,
   output logic          bsel,
   output logic [1:0]    shift,
   output logic [1:0]    ALUop,
   output logic          loadc,
   output logic          loads,
   output logic [DW-1:0] datapath_in
);
   state_t        state, next;
   logic [DW-1:0] ir;
   logic [2:0]    rn, rd, rm;
   logic [1:0]    sh, op;
   logic          legal, mov_imm, mov_reg, mvn, cmp, use_a;

   instr_decode #(.DW(DW)) u_dec (
      .ir(ir), .rn(rn), .rd(rd), .rm(rm), .sh(sh), .op(op), .datapath_in(datapath_in),
      .legal(legal), .mov_imm(mov_imm), .mov_reg(mov_reg), .mvn(mvn), .cmp(cmp), .use_a(use_a)
   );

   always_ff @(posedge clk)
      if (reset) begin
         state <= WAIT;
         ir <= '0;
      end else begin
         state <= next;
         if (state == WAIT && s) ir <= in;
      end

   assign w = state == WAIT;

   // strobes are held low while reset is asserted so an in-flight write is dropped immediately
   always_comb begin
      next = state;
      err = 1'b0;
      readnum = '0;
      writenum = '0;
      write = 1'b0;
      vsel = 1'b0;
      loada = 1'b0;
      loadb = 1'b0;
      asel = 1'b0;
      bsel = 1'b0;
      shift = SH_NONE;
      ALUop = ALU_ADD;
      loadc = 1'b0;
      loads = 1'b0;
      case (state)
         WAIT: next = s ? DECODE : WAIT;
         DECODE: begin
            next = !legal ? WAIT : mov_imm ? WRITE_IMM : use_a ? GET_A : GET_B;
            err = !legal && !reset;
         end
         GET_A: begin
            next = GET_B;
            readnum = rn;
            loada = !reset;
         end
         GET_B: begin
            next = ALU;
            readnum = rm;
            loadb = !reset;
         end
         ALU: begin
            next = cmp ? WAIT : WRITE_REG;
            shift = sh;
            asel = mov_reg || mvn;
            ALUop = mov_reg ? ALU_ADD : op;
            loads = cmp && !reset;
            loadc = !cmp && !reset;
         end
         WRITE_REG: begin
            next = WAIT;
            writenum = rd;
            write = !reset;
         end
         WRITE_IMM: begin
            next = WAIT;
            writenum = rn;
            vsel = 1'b1;
            write = !reset;
         end
         default: next = WAIT;
      endcase
   end
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: table-driven and randomized checks of datapath_ctrl against a per-instruction cycle-list model.
module tb_datapath_ctrl;
   typedef struct packed {
      logic        w, err;
      logic [2:0]  readnum, writenum;
      logic        write, vsel, loada, loadb, asel, bsel;
      logic [1:0]  shift, aluop;
      logic        loadc, loads;
      logic [15:0] dpin;
   } ctl_t;

   typedef struct {
      logic [15:0] instr;
      int          lat;
   } vec_t;

   logic        clk = 0, reset = 1, s = 0;
   logic [15:0] in = '0;
   logic        w, err, write, vsel, loada, loadb, asel, bsel, loadc, loads;
   logic [2:0]  readnum, writenum;
   logic [1:0]  shift, ALUop;
   logic [15:0] datapath_in;
   int          checks = 0, failures = 0;
   ctl_t        exp_q[$];

   datapath_ctrl dut (
      .clk(clk), .reset(reset), .s(s), .in(in), .w(w), .err(err),
      .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
      .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
      .ALUop(ALUop), .loadc(loadc), .loads(loads), .datapath_in(datapath_in)
   );

   always #5 clk = ~clk;

   function automatic ctl_t cur();
      ctl_t c;
      c = {w, err, readnum, writenum, write, vsel, loada, loadb, asel, bsel, shift, ALUop, loadc, loads, datapath_in};
      return c;
   endfunction

   task automatic check(input string name, input ctl_t got, input ctl_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // expected outputs for each cycle after the accepting edge, ending with the return to idle
   task automatic build_model(input logic [15:0] ir);
      ctl_t base, c;
      logic [2:0] opc;
      logic [1:0] op;
      bit movi, movr, alu, cmp, mvn;
      opc = ir[15:13];
      op = ir[12:11];
      movi = opc == 3'b110 && op == 2'b10;
      movr = opc == 3'b110 && op == 2'b00;
      alu = opc == 3'b101;
      cmp = alu && op == 2'b01;
      mvn = alu && op == 2'b11;
      exp_q.delete();
      base = '0;
      base.dpin = {{8{ir[7]}}, ir[7:0]};
      c = base;
      c.err = !(movi || movr || alu);
      exp_q.push_back(c);
      if (movi) begin
         c = base;
         c.writenum = ir[10:8];
         c.vsel = 1;
         c.write = 1;
         exp_q.push_back(c);
      end else if (movr || alu) begin
         if (alu && !mvn) begin
            c = base;
            c.readnum = ir[10:8];
            c.loada = 1;
            exp_q.push_back(c);
         end
         c = base;
         c.readnum = ir[2:0];
         c.loadb = 1;
         exp_q.push_back(c);
         c = base;
         c.shift = ir[4:3];
         c.aluop = movr ? 2'b00 : op;
         c.asel = movr || mvn;
         c.loads = cmp;
         c.loadc = !cmp;
         exp_q.push_back(c);
         if (!cmp) begin
            c = base;
            c.writenum = ir[7:5];
            c.write = 1;
            exp_q.push_back(c);
         end
      end
      c = base;
      c.w = 1;
      exp_q.push_back(c);
   endtask

   // entered and left #1 after a posedge with the DUT idle; s and in are scrambled while busy
   task automatic run_instr(input logic [15:0] instr, input int exp_lat);
      int lat;
      build_model(instr);
      s = 1;
      in = instr;
      @(posedge clk);
      #1;
      lat = -1;
      for (int k = 0; k < exp_q.size(); k++) begin
         s = (k == exp_q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
         in = 16'($urandom);
         @(negedge clk);
         check($sformatf("instr %h cycle %0d", instr, k), cur(), exp_q[k]);
         if (w && lat < 0) lat = k;
         @(posedge clk);
         #1;
      end
      check_int($sformatf("latency %h", instr), lat, exp_lat);
   endtask

   initial begin
      vec_t vecs[10];
      ctl_t idle;
      logic [15:0] r;
      vecs = '{'{16'hD007, 2}, '{16'hD1FE, 2}, '{16'hA148, 5}, '{16'hA801, 4}, '{16'hB860, 4},
               '{16'hB0E4, 5}, '{16'hC0A2, 4}, '{16'h0000, 1}, '{16'hE000, 1}, '{16'hD800, 1}};
      idle = '0;
      idle.w = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      check("reset idle", cur(), idle);
      @(posedge clk);
      #1;
      foreach (vecs[i]) run_instr(vecs[i].instr, vecs[i].lat);

      // reset while ADD sits in GET_B
      s = 1;
      in = 16'hA148;
      repeat (3) begin
         @(posedge clk);
         #1 s = 0;
      end
      reset = 1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check_int($sformatf("strobes in reset %0d", k), {write, loada, loadb, loadc, loads, err}, 0);
         @(posedge clk);
         #1;
      end
      reset = 0;
      @(negedge clk);
      check("after reset", cur(), idle);
      @(posedge clk);
      #1;

      // s held high: second instruction is taken on the first idle cycle
      s = 1;
      in = 16'hD007;
      @(posedge clk);
      #1 in = 16'hD1FE;
      build_model(16'hD007);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("b2b first %0d", k), cur(), exp_q[k]);
         @(posedge clk);
         #1;
      end
      s = 0;
      build_model(16'hD1FE);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("b2b second %0d", k), cur(), exp_q[k]);
         @(posedge clk);
         #1;
      end

      for (int i = 0; i < 60; i++) begin
         r = 16'($urandom);
         case ($urandom_range(0, 7))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2: r[15:11] = 5'b10100;
            3: r[15:11] = 5'b10101;
            4: r[15:11] = 5'b10110;
            5: r[15:11] = 5'b10111;
            default: ;
         endcase
         build_model(r);
         run_instr(r, exp_q.size() - 1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
